// File: rtl/makehint_hint_packer.sv
// ML-DSA makehint hint packer: turns the per-coefficient hint stream into the
// signature h field. Optional build macro: MAKEHINT_PACK_ZEROIZE_EN (adds zeroize_i).
module makehint_hint_packer #(
    parameter int unsigned OMEGA  = 75,
    parameter int unsigned K      = 8,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
`ifdef MAKEHINT_PACK_ZEROIZE_EN
    input  logic              zeroize_i,
`endif
    input  logic              start_i,
    input  logic              hint_valid_i,
    input  logic [3:0]        hint_i,
    output logic              hint_ready_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       out_data_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              done_o,
    output logic              invalid_o
);

    localparam int unsigned BC_W = $clog2(OMEGA + K + 5);
    localparam int unsigned TC_W = $clog2(OMEGA + 2);
    localparam int unsigned PC_W = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [2:0] {
        IDLE,
        PACK,
        PAD,
        COUNTS,
        FLUSH
    } state_t;

    state_t          state;
    logic [5:0]      beat_cnt;
    logic [PC_W-1:0] poly_cnt;
    logic [PC_W-1:0] cnt_idx;
    logic [TC_W-1:0] total_cnt;
    logic [BC_W-1:0] byte_cnt;
    logic [7:0]      cum [K];
    logic [7:0]      bytes_q [8];
    logic [2:0]      pend;

    logic [7:0]      bytes_n [8];
    logic [7:0]      push_b [4];
    logic [2:0]      pend_n;
    logic [2:0]      push_cnt;
    logic [TC_W-1:0] total_n;
    logic [7:0]      cum_n;
    logic            pop;
    logic            acc;
    logic            over;
    logic            last_beat;

    assign out_data_o = {bytes_q[3], bytes_q[2], bytes_q[1], bytes_q[0]};

    always_comb begin
        int unsigned room;
        int unsigned hits;
        int unsigned npush;
        int unsigned base;
        int unsigned tsum;

        pop = out_valid_o & out_ready_i;
        acc = (state == PACK) & hint_valid_i & hint_ready_o;

        room = (32'(byte_cnt) >= OMEGA) ? 0 : OMEGA - 32'(byte_cnt);
        if (room > 4) room = 4;

        hits  = 0;
        npush = 0;
        for (int unsigned j = 0; j < 4; j++) push_b[j] = '0;

        case (state)
            PACK: begin
                if (acc) begin
                    // set bits compact in ascending order; anything past OMEGA is dropped
                    for (int unsigned i = 0; i < 4; i++) begin
                        if (hint_i[i]) begin
                            if (hits < room) push_b[hits[1:0]] = {beat_cnt, i[1:0]};
                            hits = hits + 1;
                        end
                    end
                    npush = (hits < room) ? hits : room;
                end
            end
            PAD: begin
                if (pend <= 3'd3) npush = room;
            end
            COUNTS: begin
                if (pend <= 3'd3) begin
                    npush     = 1;
                    push_b[0] = cum[cnt_idx];
                end
            end
            FLUSH: begin
                if (pend != 3'd0 && pend <= 3'd3) npush = 4 - 32'(pend);
            end
            default: ;
        endcase

        tsum      = 32'(total_cnt) + hits;
        over      = (tsum > OMEGA);
        total_n   = TC_W'((tsum > OMEGA + 1) ? OMEGA + 1 : tsum);
        cum_n     = 8'((tsum > OMEGA) ? OMEGA : tsum);
        last_beat = acc && (beat_cnt == 6'd63) && (32'(poly_cnt) == K - 1);
        push_cnt  = 3'(npush);

        // pop shifts the upper half down first, then pushes append behind what remains
        base = (pop && pend >= 3'd4) ? 32'(pend) - 4 : 32'(pend);
        for (int unsigned j = 0; j < 8; j++) begin
            if (pop) bytes_n[j] = (j < 4) ? bytes_q[j + 4] : 8'h00;
            else     bytes_n[j] = bytes_q[j];
        end
        for (int unsigned j = 0; j < 4; j++) begin
            if (j < npush) bytes_n[3'(base + j)] = push_b[j];
        end
        pend_n = 3'(base + npush);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            poly_cnt     <= '0;
            cnt_idx      <= '0;
            total_cnt    <= '0;
            byte_cnt     <= '0;
            pend         <= '0;
            for (int unsigned j = 0; j < K; j++) cum[j] <= '0;
            for (int unsigned j = 0; j < 8; j++) bytes_q[j] <= '0;
            hint_ready_o <= 1'b0;
            out_valid_o  <= 1'b0;
            out_addr_o   <= '0;
            done_o       <= 1'b0;
            invalid_o    <= 1'b0;
        end
`ifdef MAKEHINT_PACK_ZEROIZE_EN
        else if (zeroize_i) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            poly_cnt     <= '0;
            cnt_idx      <= '0;
            total_cnt    <= '0;
            byte_cnt     <= '0;
            pend         <= '0;
            for (int unsigned j = 0; j < K; j++) cum[j] <= '0;
            for (int unsigned j = 0; j < 8; j++) bytes_q[j] <= '0;
            hint_ready_o <= 1'b0;
            out_valid_o  <= 1'b0;
            out_addr_o   <= '0;
            done_o       <= 1'b0;
            invalid_o    <= 1'b0;
        end
`endif
        else begin
            for (int unsigned j = 0; j < 8; j++) bytes_q[j] <= bytes_n[j];
            pend         <= pend_n;
            out_valid_o  <= (pend_n >= 3'd4);
            byte_cnt     <= byte_cnt + BC_W'(push_cnt);
            done_o       <= 1'b0;
            hint_ready_o <= 1'b0;
            if (pop) out_addr_o <= out_addr_o + ADDR_W'(1);

            case (state)
                IDLE: begin
                    if (start_i) begin
                        state        <= PACK;
                        beat_cnt     <= '0;
                        poly_cnt     <= '0;
                        cnt_idx      <= '0;
                        total_cnt    <= '0;
                        byte_cnt     <= '0;
                        pend         <= '0;
                        for (int unsigned j = 0; j < K; j++) cum[j] <= '0;
                        for (int unsigned j = 0; j < 8; j++) bytes_q[j] <= '0;
                        out_valid_o  <= 1'b0;
                        out_addr_o   <= '0;
                        invalid_o    <= 1'b0;
                        hint_ready_o <= 1'b1;
                    end
                end
                PACK: begin
                    hint_ready_o <= !last_beat && (pend_n <= 3'd3);
                    if (acc) begin
                        total_cnt <= total_n;
                        if (over) invalid_o <= 1'b1;
                        beat_cnt <= beat_cnt + 6'd1;
                        if (beat_cnt == 6'd63) begin
                            cum[poly_cnt] <= cum_n;
                            poly_cnt      <= poly_cnt + PC_W'(1);
                            if (32'(poly_cnt) == K - 1) state <= PAD;
                        end
                    end
                end
                PAD: begin
                    if (32'(byte_cnt) >= OMEGA) state <= COUNTS;
                end
                COUNTS: begin
                    if (pend <= 3'd3) begin
                        cnt_idx <= cnt_idx + PC_W'(1);
                        if (32'(cnt_idx) == K - 1) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (pop && pend_n == 3'd0) begin
                        done_o <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_makehint_hint_packer.sv
// Self-checking bench for makehint_hint_packer: table of packing scenarios,
// scoreboard of expected output words built from a reference encoder.
`timescale 1ns/1ps
module tb_makehint_hint_packer;

    localparam int OMEGA  = 75;
    localparam int K      = 8;
    localparam int ADDR_W = 5;
    localparam int NWORDS = 21;

    logic              clk;
    logic              rst;
    logic              zeroize;
    logic              start;
    logic              beat_valid;
    logic [3:0]        beat_bits;
    logic              beat_ready;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              done;
    logic              invalid;

    makehint_hint_packer #(
        .OMEGA (OMEGA),
        .K     (K),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef MAKEHINT_PACK_ZEROIZE_EN
        .zeroize_i   (zeroize),
`endif
        .start_i     (start),
        .hint_valid_i(beat_valid),
        .hint_i      (beat_bits),
        .hint_ready_o(beat_ready),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_addr_o  (out_addr),
        .done_o      (done),
        .invalid_o   (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       data;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    typedef struct {
        int          kind;
        bit          rnd;
        bit          consts;
        logic        exp_inv;
        logic [31:0] w0;
        logic [31:0] w18;
        logic [31:0] w19;
        logic [31:0] w20;
    } vec_t;

    int          n_checks;
    int          n_fail;
    logic [3:0]  pat [K][64];
    exp_t        sb [$];
    exp_t        mon_e;
    logic [31:0] got [NWORDS];
    logic [31:0] dense_ref [NWORDS];
    int          n_got;
    int          done_cnt;
    int          hr_viol;
    bit          mon_en;
    bit          rand_ready;
    logic        model_invalid;
    vec_t        vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // output sink backpressure
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // monitor: words are taken from the scoreboard as the sink accepts them
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (beat_ready && out_valid) hr_viol++;
                if (done) done_cnt++;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL extra_word: got addr %0d data 0x%08h, expected no word", out_addr, out_data);
                    end else begin
                        mon_e = sb.pop_front();
                        check("word_data", out_data, mon_e.data);
                        check("word_addr", 32'(out_addr), 32'(mon_e.addr));
                        if (n_got < NWORDS) got[n_got] = out_data;
                        n_got++;
                    end
                end
            end
        end
    end

    task automatic fill_pattern(input int kind);
        for (int p = 0; p < K; p++)
            for (int b = 0; b < 64; b++)
                pat[p][b] = 4'h0;
        case (kind)
            1: pat[0][1] = 4'b0010;
            2: pat[0][0] = 4'hF;
            3: for (int b = 0; b < 19; b++) pat[0][b] = 4'hF;
            4: begin
                for (int p = 0; p < K; p++)
                    for (int b = 0; b < 64; b++)
                        for (int i = 0; i < 4; i++)
                            pat[p][b][i] = ($urandom_range(0, 39) == 0);
            end
            6: begin
                for (int b = 0; b < 18; b++) pat[0][b] = 4'hF;
                pat[0][18] = 4'b0011;
                pat[0][19] = 4'hF;
            end
            default: ;
        endcase
    endtask

    task automatic build_model();
        logic [7:0] mb [NWORDS*4];
        int   n;
        int   tot;
        exp_t e;
        for (int i = 0; i < NWORDS*4; i++) mb[i] = 8'h00;
        n   = 0;
        tot = 0;
        for (int p = 0; p < K; p++) begin
            for (int c = 0; c < 256; c++) begin
                if (pat[p][c/4][c%4]) begin
                    if (n < OMEGA) begin
                        mb[n] = 8'(c);
                        n++;
                    end
                    tot++;
                end
            end
            mb[OMEGA + p] = 8'((tot > OMEGA) ? OMEGA : tot);
        end
        model_invalid = (tot > OMEGA);
        for (int w = 0; w < NWORDS; w++) begin
            e.data = {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
            e.addr = ADDR_W'(w);
            sb.push_back(e);
        end
    endtask

    task automatic send_beat(input logic [3:0] h);
        int n;
        beat_valid = 1'b1;
        beat_bits  = h;
        n          = 0;
        while (!beat_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!beat_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_accept_timeout: hint_ready stayed 0, expected 1");
        end
        @(negedge clk);
        beat_valid = 1'b0;
    endtask

    task automatic run_packing(input bit rnd);
        int t;
        sb.delete();
        n_got      = 0;
        done_cnt   = 0;
        hr_viol    = 0;
        rand_ready = rnd;
        build_model();
        mon_en = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_invalid_clear", 32'(invalid), 32'd0);
        check("start_ready", 32'(beat_ready), 32'd1);
        for (int p = 0; p < K; p++) begin
            for (int b = 0; b < 64; b++) begin
                if (rnd && $urandom_range(0, 3) == 0) @(negedge clk);
                send_beat(pat[p][b]);
            end
        end
        t = 0;
        while (done_cnt == 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (6) @(negedge clk);
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("word_count", 32'(n_got), 32'(NWORDS));
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        check("ready_while_full", 32'(hr_viol), 32'd0);
        check("invalid_model", 32'(invalid), 32'(model_invalid));
        check("idle_ready_low", 32'(beat_ready), 32'd0);
        mon_en = 1'b0;
    endtask

    initial begin
        int diff;
        n_checks   = 0;
        n_fail     = 0;
        mon_en     = 1'b0;
        rand_ready = 1'b0;
        zeroize    = 1'b0;
        rst        = 1'b1;
        start      = 1'b0;
        beat_valid = 1'b0;
        beat_bits  = 4'h0;

        //         kind rnd consts inv   w0            w18           w19           w20
        vecs[0] = '{0, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[1] = '{1, 1'b0, 1'b1, 1'b0, 32'h00000005, 32'h01000000, 32'h01010101, 32'h00010101};
        vecs[2] = '{2, 1'b0, 1'b1, 1'b0, 32'h03020100, 32'h04000000, 32'h04040404, 32'h00040404};
        vecs[3] = '{3, 1'b0, 1'b1, 1'b1, 32'h03020100, 32'h4B4A4948, 32'h4B4B4B4B, 32'h004B4B4B};
        vecs[4] = '{6, 1'b0, 1'b1, 1'b1, 32'h03020100, 32'h4B4C4948, 32'h4B4B4B4B, 32'h004B4B4B};
        vecs[5] = '{4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[6] = '{5, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};

        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_invalid", 32'(invalid), 32'd0);
        check("rst_hint_ready", 32'(beat_ready), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].kind != 5) fill_pattern(vecs[v].kind);
            run_packing(vecs[v].rnd);
            if (vecs[v].consts) begin
                check($sformatf("v%0d_word0", v), got[0], vecs[v].w0);
                check($sformatf("v%0d_word18", v), got[18], vecs[v].w18);
                check($sformatf("v%0d_word19", v), got[19], vecs[v].w19);
                check($sformatf("v%0d_word20", v), got[20], vecs[v].w20);
                check($sformatf("v%0d_invalid", v), 32'(invalid), 32'(vecs[v].exp_inv));
            end
            if (vecs[v].kind == 4)
                for (int w = 0; w < NWORDS; w++) dense_ref[w] = got[w];
            if (vecs[v].kind == 5) begin
                diff = 0;
                for (int w = 0; w < NWORDS; w++) if (got[w] !== dense_ref[w]) diff++;
                check("dense_stream_match", 32'(diff), 32'd0);
            end
        end

        // abort mid-PACK with a backpressured sink, then a clean packing
        fill_pattern(4);
        rand_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 100; b++) send_beat(pat[b/64][b%64]);
        #2;
        rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_data", out_data, 32'd0);
        check("abort_out_addr", 32'(out_addr), 32'd0);
        check("abort_hint_ready", 32'(beat_ready), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_invalid", 32'(invalid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fill_pattern(1);
        run_packing(1'b0);
        check("post_abort_word0", got[0], 32'h00000005);
        check("post_abort_word18", got[18], 32'h01000000);
        check("post_abort_word20", got[20], 32'h00010101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
